// File: rtl/lsu_io_pkg.sv
// Shared LSU I/O constants: input-peripheral window, register offsets and decode helpers.
// The LSU read mux reuses ip_hit() to select o_rd_ip_data.
package lsu_io_pkg;

    localparam logic [15:0] IP_BASE     = 16'h7800;
    localparam logic [4:0]  IP_SW_OFS   = 5'h00;
    localparam logic [4:0]  IP_BTN_OFS  = 5'h04;
    localparam logic [4:0]  IP_FLAG_OFS = 5'h08;

    // 32-byte window: match on address bits [15:5]
    localparam int          IP_WIN_LSB  = 5;
    localparam logic [10:0] IP_WIN_TAG  = IP_BASE[15:IP_WIN_LSB];

    typedef enum logic [1:0] {
        IP_REG_NONE,
        IP_REG_SW,
        IP_REG_BTN,
        IP_REG_FLAG
    } ip_reg_e;

    function automatic logic ip_hit(input logic [15:0] addr);
        return addr[15:IP_WIN_LSB] == IP_WIN_TAG;
    endfunction

    function automatic ip_reg_e ip_decode(input logic [15:0] addr);
        logic [4:0] ofs;
        ofs = {addr[4:2], 2'b00};
        if (!ip_hit(addr)) return IP_REG_NONE;
        case (ofs)
            IP_SW_OFS:   return IP_REG_SW;
            IP_BTN_OFS:  return IP_REG_BTN;
            IP_FLAG_OFS: return IP_REG_FLAG;
            default:     return IP_REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/input_periph_lsu_if.sv
// LSU-side bus of the input peripheral: address, store data/strobe and read data.
interface input_periph_lsu_if;
    logic [15:0] lsu_addr;
    logic [31:0] st_data;
    logic        lsu_wren;
    logic [31:0] rd_ip_data;

    modport master (output lsu_addr, output st_data, output lsu_wren, input rd_ip_data);
    modport slave  (input lsu_addr, input st_data, input lsu_wren, output rd_ip_data);
endinterface

// File: rtl/sync_debounce.sv
// 2-FF synchroniser plus tick-sampled debounce for a W-bit vector.
// Debounce is present only when INPUT_PERIPH_DEBOUNCE_EN is defined.
module sync_debounce #(
    parameter int W         = 1,
    parameter int DB_CYCLES = 2,
    parameter bit INVERT    = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_db
);
    localparam logic [W-1:0] INV_MASK = INVERT ? {W{1'b1}} : {W{1'b0}};

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_db;

    // Polarity folded into the first stage so a reset value of 0 means "released".
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_raw ^ INV_MASK;
            r_sync <= r_meta;
        end
    end

`ifdef INPUT_PERIPH_DEBOUNCE_EN
    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_last;
    logic             w_tick;
    logic [W-1:0]     w_stable;

    assign w_tick   = (r_cnt == CNT_LAST);
    assign w_stable = ~(r_sync ^ r_last);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_last <= '0;
            r_db   <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_last <= r_sync;
                r_db   <= (r_sync & w_stable) | (r_db & ~w_stable);
            end
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_db <= '0;
        else         r_db <= r_sync;
    end
`endif

    assign o_db = r_db;
endmodule

// File: rtl/input_periph_lsu.sv
// Input peripheral at 0x7800-0x781F: debounced switches/buttons and W1C press flags.
// Optional debounce selected by INPUT_PERIPH_DEBOUNCE_EN.
module input_periph_lsu
    import lsu_io_pkg::*;
#(
    parameter int SW_W           = 17,
    parameter int BTN_W          = 4,
    parameter bit BTN_ACTIVE_LOW = 1'b1,
    parameter int DB_CYCLES      = 50000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input_periph_lsu_if.slave    bus,
    input  logic [SW_W-1:0]      i_io_sw,
    input  logic [BTN_W-1:0]     i_io_btn,
    output logic                 o_btn_pending
);
    logic [SW_W-1:0]  w_sw_db;
    logic [BTN_W-1:0] w_btn_db;
    logic [BTN_W-1:0] w_rise;
    logic [BTN_W-1:0] w_clr;
    ip_reg_e          w_sel;
    logic [31:0]      w_rd;

    logic [BTN_W-1:0] r_btn_prev;
    logic [BTN_W-1:0] r_flag;
    logic             r_pending;

    sync_debounce #(.W(SW_W), .DB_CYCLES(DB_CYCLES), .INVERT(1'b0)) u_sw_db (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_raw   (i_io_sw),
        .o_db    (w_sw_db)
    );

    sync_debounce #(.W(BTN_W), .DB_CYCLES(DB_CYCLES), .INVERT(BTN_ACTIVE_LOW)) u_btn_db (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_raw   (i_io_btn),
        .o_db    (w_btn_db)
    );

    assign w_sel  = ip_decode(bus.lsu_addr);
    assign w_rise = w_btn_db & ~r_btn_prev;
    assign w_clr  = (bus.lsu_wren && (w_sel == IP_REG_FLAG)) ? bus.st_data[BTN_W-1:0] : '0;

    // A rising edge in the same cycle as a W1C of that bit keeps the flag set.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btn_prev <= '0;
            r_flag     <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_btn_prev <= w_btn_db;
            r_flag     <= (r_flag & ~w_clr) | w_rise;
            r_pending  <= |r_flag;
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_sel)
            IP_REG_SW:   w_rd[SW_W-1:0]  = w_sw_db;
            IP_REG_BTN:  w_rd[BTN_W-1:0] = w_btn_db;
            IP_REG_FLAG: w_rd[BTN_W-1:0] = r_flag;
            default:     w_rd = '0;
        endcase
    end

    assign bus.rd_ip_data = w_rd;
    assign o_btn_pending  = r_pending;
endmodule

// File: tb/tb_input_periph_lsu.sv
// Directed bench for input_periph_lsu (DB_CYCLES=4, SW_W=17, BTN_W=4, active-low buttons).
module tb_input_periph_lsu;
    logic        clk;
    logic        rst;
    logic [16:0] sw;
    logic [3:0]  btn;
    logic        pending;
    int          checks;
    int          failures;

    input_periph_lsu_if bus_if ();

    input_periph_lsu #(
        .SW_W(17), .BTN_W(4), .BTN_ACTIVE_LOW(1'b1), .DB_CYCLES(4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .bus           (bus_if.slave),
        .i_io_sw       (sw),
        .i_io_btn      (btn),
        .o_btn_pending (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
        bus_if.lsu_addr = a;
        bus_if.lsu_wren = 1'b0;
        #1;
        chk(tag, bus_if.rd_ip_data, exp);
    endtask

    task automatic store(input logic [15:0] a, input logic [31:0] d);
        bus_if.lsu_addr = a;
        bus_if.st_data  = d;
        bus_if.lsu_wren = 1'b1;
        step(1);
        bus_if.lsu_wren = 1'b0;
        bus_if.st_data  = 32'h0;
    endtask

    initial begin
        logic        found;
        logic [31:0] exp_sw;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sw       = 17'h0;
        btn      = 4'hF;
        bus_if.lsu_addr = 16'h7800;
        bus_if.st_data  = 32'h0;
        bus_if.lsu_wren = 1'b0;

        step(2);
        chk_rd("reset_sw", 16'h7800, 32'h0);
        chk("reset_pending", {31'b0, pending}, 32'h0);
        rst = 1'b0;

        // Switch read, address bits [1:0] ignored
        sw = 17'h0A5A5;
        step(12);
        chk_rd("sw_read", 16'h7800, 32'h0000A5A5);
        chk_rd("sw_read_unaligned", 16'h7802, 32'h0000A5A5);

        // Glitch rejection
        sw = 17'h0;
        step(12);
        chk_rd("sw_zero", 16'h7800, 32'h0);
        sw = 17'h1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
`ifdef INPUT_PERIPH_DEBOUNCE_EN
            exp_sw = 32'h0;
`else
            exp_sw = (k == 3 || k == 4) ? 32'h1 : 32'h0;
`endif
            chk_rd($sformatf("sw_glitch_c%0d", k), 16'h7800, exp_sw);
            if (k == 2) sw = 17'h0;
        end
        sw = 17'h1;
        step(12);
        chk_rd("sw_held", 16'h7800, 32'h1);

        // Button press and W1C
        btn = 4'b1101;
        step(12);
        chk_rd("btn_level", 16'h7804, 32'h2);
        chk_rd("flag_set", 16'h7808, 32'h2);
        chk("pending_set", {31'b0, pending}, 32'h1);
        store(16'h7808, 32'h2);
        chk_rd("flag_w1c", 16'h7808, 32'h0);
        chk("pending_lag", {31'b0, pending}, 32'h1);
        step(1);
        chk("pending_clear", {31'b0, pending}, 32'h0);

        // Set-vs-clear collision on btn[0]
        btn   = 4'b1100;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            bus_if.lsu_addr = 16'h7804;
            #1;
            if (bus_if.rd_ip_data[0]) found = 1'b1;
        end
        chk("collision_rise_seen", {31'b0, found}, 32'h1);
        store(16'h7808, 32'h1);
        chk_rd("collision_set_wins", 16'h7808, 32'h1);

        // Decode
        chk_rd("decode_unused_ofs", 16'h7810, 32'h0);
        chk_rd("decode_ofs_0c", 16'h780C, 32'h0);
        chk_rd("decode_outside", 16'h7000, 32'h0);
        chk_rd("decode_alias_hi", 16'hF808, 32'h0);
        store(16'h7804, 32'hF);
        chk_rd("btn_store_ignored", 16'h7804, 32'h3);
        chk_rd("flag_after_btn_store", 16'h7808, 32'h1);
        store(16'h7008, 32'h1);
        chk_rd("flag_outside_store", 16'h7808, 32'h1);

        // Flags are sticky after release
        btn = 4'hF;
        step(12);
        chk_rd("btn_released", 16'h7804, 32'h0);
        chk_rd("flag_sticky", 16'h7808, 32'h1);
        store(16'h7808, 32'hFFFFFFFF);
        chk_rd("flag_clear_all", 16'h7808, 32'h0);

        // Reset asserted mid-run, between clock edges
        sw  = 17'h1FFFF;
        btn = 4'b1011;
        step(14);
        chk_rd("pre_reset_sw", 16'h7800, 32'h0001FFFF);
        chk("pre_reset_pending", {31'b0, pending}, 32'h1);
        #1;
        rst = 1'b1;
        chk_rd("async_reset_sw", 16'h7800, 32'h0);
        chk("async_reset_pending", {31'b0, pending}, 32'h0);
        step(1);
        rst = 1'b0;
        step(14);
        chk_rd("post_reset_sw", 16'h7800, 32'h0001FFFF);
        chk_rd("post_reset_btn", 16'h7804, 32'h4);
        chk("post_reset_pending", {31'b0, pending}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
